// File: rtl/ni_initiator.sv
// Core-side NoC initiator: serializes request packets into head/body/tail flits
// for the NI, reassembles response flits into packets, and counts outstanding requests.
module ni_initiator #(
  parameter int FLIT_W          = 16,
  parameter int TOTAL_FLITS     = 6,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BODY_W         = (TOTAL_FLITS - 2) * FLIT_W,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FLIT_W-1:0] req_head,
  input  logic [FLIT_W-1:0] req_tail,
  input  logic [BODY_W-1:0] req_body,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_flit_valid,
  input  logic              i_ni_ready,
  input  logic [FLIT_W-1:0] i_resp_flit,
  input  logic              i_resp_valid,
  output logic              o_resp_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [FLIT_W-1:0] resp_head,
  output logic [FLIT_W-1:0] resp_tail,
  output logic [BODY_W-1:0] resp_body,
  output logic [CNT_W-1:0]  o_outstanding,
  output logic              o_err_unexpected
);

  localparam int IDX_W = (TOTAL_FLITS - 2 > 1) ? $clog2(TOTAL_FLITS - 2) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(TOTAL_FLITS - 3);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_HOLD} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic [FLIT_W-1:0] tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
  logic [BODY_W-1:0] tx_body_q, tx_body_d;
  logic [FLIT_W-1:0] o_flit_q, o_flit_d;
  logic              o_flit_valid_q, o_flit_valid_d;

  rx_state_e         rx_state_q, rx_state_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic              rx_last_q, rx_last_d;
  logic [FLIT_W-1:0] resp_head_q, resp_head_d, resp_tail_q, resp_tail_d;
  logic [BODY_W-1:0] resp_body_q, resp_body_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_done, rx_accept;

  assign req_ready    = (tx_state_q == TX_IDLE) && (cnt_q < CNT_MAX);
  assign o_resp_ready = (rx_state_q != RX_HOLD);
  assign tx_done      = (tx_state_q == TX_TAIL);
  assign rx_accept    = (rx_state_q == RX_HOLD) && resp_ready;

  // NOTE: packet buffers are reset too, because the response outputs must read zero after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_q     <= TX_IDLE;
      tx_idx_q       <= '0;
      tx_head_q      <= '0;
      tx_tail_q      <= '0;
      tx_body_q      <= '0;
      o_flit_q       <= '0;
      o_flit_valid_q <= 1'b0;
      rx_state_q     <= RX_IDLE;
      rx_idx_q       <= '0;
      rx_last_q      <= 1'b0;
      resp_head_q    <= '0;
      resp_tail_q    <= '0;
      resp_body_q    <= '0;
      resp_valid_q   <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      tx_state_q     <= tx_state_d;
      tx_idx_q       <= tx_idx_d;
      tx_head_q      <= tx_head_d;
      tx_tail_q      <= tx_tail_d;
      tx_body_q      <= tx_body_d;
      o_flit_q       <= o_flit_d;
      o_flit_valid_q <= o_flit_valid_d;
      rx_state_q     <= rx_state_d;
      rx_idx_q       <= rx_idx_d;
      rx_last_q      <= rx_last_d;
      resp_head_q    <= resp_head_d;
      resp_tail_q    <= resp_tail_d;
      resp_body_q    <= resp_body_d;
      resp_valid_q   <= resp_valid_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_head_d  = tx_head_q;
    tx_tail_d  = tx_tail_q;
    tx_body_d  = tx_body_q;
    case (tx_state_q)
      TX_IDLE: if (req_valid && req_ready) begin
        tx_head_d  = req_head;
        tx_tail_d  = req_tail;
        tx_body_d  = req_body;
        tx_state_d = TX_HEAD;
      end
      TX_HEAD: if (i_ni_ready) begin
        tx_idx_d   = IDX_TOP;
        tx_state_d = TX_BODY;
      end
      TX_BODY: begin
        if (tx_idx_q == '0) tx_state_d = TX_TAIL;
        else                tx_idx_d   = tx_idx_q - IDX_W'(1);
      end
      TX_TAIL: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Flit outputs are decoded from next-state values so they register in step with the FSM.
  always_comb begin
    o_flit_d       = '0;
    o_flit_valid_d = 1'b0;
    case (tx_state_d)
      TX_HEAD: begin
        o_flit_d       = tx_head_d;
        o_flit_valid_d = 1'b1;
      end
      TX_BODY: o_flit_d = tx_body_d[int'(tx_idx_d)*FLIT_W +: FLIT_W];
      TX_TAIL: o_flit_d = tx_tail_d;
      default: o_flit_d = '0;
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_idx_d    = rx_idx_q;
    rx_last_d   = rx_last_q;
    resp_head_d = resp_head_q;
    resp_tail_d = resp_tail_q;
    resp_body_d = resp_body_q;
    case (rx_state_q)
      RX_IDLE: if (i_resp_valid) begin
        resp_head_d = i_resp_flit;
        rx_idx_d    = IDX_TOP;
        rx_last_d   = 1'b0;
        rx_state_d  = RX_COLLECT;
      end
      RX_COLLECT: if (i_resp_valid) begin
        if (rx_last_q) begin
          resp_tail_d = i_resp_flit;
          rx_state_d  = RX_HOLD;
        end else begin
          resp_body_d[int'(rx_idx_q)*FLIT_W +: FLIT_W] = i_resp_flit;
          if (rx_idx_q == '0) rx_last_d = 1'b1;
          else                rx_idx_d  = rx_idx_q - IDX_W'(1);
        end
      end
      RX_HOLD: if (resp_ready) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    resp_valid_d = (rx_state_d == RX_HOLD);
    err_d        = (rx_state_q == RX_IDLE) && i_resp_valid && (cnt_q == '0);
  end

  // Simultaneous send and accept cancel; an accept with nothing outstanding floors at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (tx_done && !rx_accept)                       cnt_d = cnt_q + CNT_W'(1);
    else if (!tx_done && rx_accept && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  assign o_flit           = o_flit_q;
  assign o_flit_valid     = o_flit_valid_q;
  assign resp_valid       = resp_valid_q;
  assign resp_head        = resp_head_q;
  assign resp_tail        = resp_tail_q;
  assign resp_body        = resp_body_q;
  assign o_outstanding    = cnt_q;
  assign o_err_unexpected = err_q;

endmodule

// File: tb/tb_ni_initiator.sv
// Directed self-checking bench for ni_initiator (FLIT_W=16, TOTAL_FLITS=6, MAX_OUTSTANDING=4).
module tb_ni_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [15:0] req_head, req_tail;
  logic [63:0] req_body;
  logic [15:0] o_flit;
  logic        o_flit_valid;
  logic        i_ni_ready;
  logic [15:0] i_resp_flit;
  logic        i_resp_valid, o_resp_ready;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_head, resp_tail;
  logic [63:0] resp_body;
  logic [2:0]  o_outstanding;
  logic        o_err_unexpected;

  int n_tests = 0;
  int n_fail  = 0;

  ni_initiator #(.FLIT_W(16), .TOTAL_FLITS(6), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_head(req_head), .req_tail(req_tail), .req_body(req_body),
    .o_flit(o_flit), .o_flit_valid(o_flit_valid), .i_ni_ready(i_ni_ready),
    .i_resp_flit(i_resp_flit), .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_head(resp_head), .resp_tail(resp_tail), .resp_body(resp_body),
    .o_outstanding(o_outstanding), .o_err_unexpected(o_err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},    req_ready,        1);
    check({tag, " o_flit"},       o_flit,           0);
    check({tag, " o_flit_valid"}, o_flit_valid,     0);
    check({tag, " o_resp_ready"}, o_resp_ready,     1);
    check({tag, " resp_valid"},   resp_valid,       0);
    check({tag, " resp_head"},    resp_head,        0);
    check({tag, " resp_body"},    resp_body,        0);
    check({tag, " resp_tail"},    resp_tail,        0);
    check({tag, " outstanding"},  o_outstanding,    0);
    check({tag, " err"},          o_err_unexpected, 0);
  endtask

  // Full request with i_ni_ready=1; optionally accepts a held response on the tail cycle.
  task automatic send_req(input logic [15:0] h, input logic [63:0] b, input logic [15:0] t,
                          input bit accept_at_tail);
    logic [15:0] exp_flit;
    check("req_ready before send", req_ready, 1);
    req_valid = 1'b1; req_head = h; req_body = b; req_tail = t;
    tick();
    req_valid = 1'b0;
    check("head flit", o_flit, h);
    check("head valid", o_flit_valid, 1);
    check("req_ready busy", req_ready, 0);
    for (int k = 3; k >= 0; k--) begin
      tick();
      exp_flit = b[k*16 +: 16];
      check("body flit", o_flit, exp_flit);
      check("body valid low", o_flit_valid, 0);
    end
    tick();
    check("tail flit", o_flit, t);
    check("tail valid low", o_flit_valid, 0);
    resp_ready = accept_at_tail;
    tick();
    resp_ready = 1'b0;
    check("idle flit zero", o_flit, 0);
  endtask

  // Streams one gap-free response packet derived from base; body[k] = base + 0x10*(k+1).
  task automatic send_resp(input logic [15:0] base, input bit accept);
    logic [15:0] flits [6];
    logic [63:0] exp_body;
    flits[0] = base;
    for (int k = 3; k >= 0; k--) begin
      flits[4-k] = base + 16'(16 * (k + 1));
      exp_body[k*16 +: 16] = base + 16'(16 * (k + 1));
    end
    flits[5] = base + 16'h00F0;
    for (int i = 0; i < 6; i++) begin
      i_resp_valid = 1'b1; i_resp_flit = flits[i];
      tick();
    end
    i_resp_valid = 1'b0;
    check("resp_valid after tail", resp_valid, 1);
    check("resp head", resp_head, base);
    check("resp body", resp_body, exp_body);
    check("resp tail", resp_tail, flits[5]);
    if (accept) begin
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("resp_valid drop", resp_valid, 0);
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_head = '0; req_tail = '0; req_body = '0;
    i_ni_ready = 1'b1; i_resp_flit = '0; i_resp_valid = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // Basic serialization
    send_req(16'h1111, 64'h2333_2222_2111_2000, 16'h3333, 1'b0);
    check("req_ready after tx", req_ready, 1);
    check("outstanding after tx1", o_outstanding, 1);

    // NI stall in TX_HEAD: 5 stalled cycles plus the accepting one
    req_valid = 1'b1; req_head = 16'h4444; req_body = 64'h5003_5002_5001_5000; req_tail = 16'h6666;
    i_ni_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("stall head", o_flit, 16'h4444);
      check("stall valid", o_flit_valid, 1);
      check("stall req_ready", req_ready, 0);
      i_ni_ready = (i == 5);
      tick();
    end
    check("post-stall body3", o_flit, 16'h5003);
    tick(); check("post-stall body2", o_flit, 16'h5002);
    tick(); check("post-stall body1", o_flit, 16'h5001);
    tick(); check("post-stall body0", o_flit, 16'h5000);
    tick(); check("post-stall tail", o_flit, 16'h6666);
    tick();
    check("outstanding after tx2", o_outstanding, 2);

    // Response with a 2-cycle gap, then a held response
    i_resp_valid = 1'b1; i_resp_flit = 16'hA0A0; tick();
    check("no err with outstanding", o_err_unexpected, 0);
    i_resp_flit = 16'h00B3; tick();
    i_resp_flit = 16'h00B2; tick();
    i_resp_valid = 1'b0; tick(); tick();
    check("gap resp_ready", o_resp_ready, 1);
    check("gap resp_valid", resp_valid, 0);
    i_resp_valid = 1'b1; i_resp_flit = 16'h00B1; tick();
    i_resp_flit = 16'h00B0; tick();
    i_resp_flit = 16'hC0C0; tick();
    i_resp_flit = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      check("hold resp_valid", resp_valid, 1);
      check("hold head", resp_head, 16'hA0A0);
      check("hold body", resp_body, 64'h00B3_00B2_00B1_00B0);
      check("hold tail", resp_tail, 16'hC0C0);
      check("hold o_resp_ready", o_resp_ready, 0);
      tick();
    end
    i_resp_valid = 1'b0;
    check("hold body after stray flits", resp_body, 64'h00B3_00B2_00B1_00B0);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    check("accept resp_valid", resp_valid, 0);
    check("accept o_resp_ready", o_resp_ready, 1);
    check("outstanding after rx", o_outstanding, 1);

    // Fill to MAX_OUTSTANDING
    send_req(16'h0101, 64'h0203_0202_0201_0200, 16'h0303, 1'b0);
    send_req(16'h0111, 64'h0213_0212_0211_0210, 16'h0313, 1'b0);
    send_req(16'h0121, 64'h0223_0222_0221_0220, 16'h0323, 1'b0);
    check("full outstanding", o_outstanding, 4);
    check("full req_ready", req_ready, 0);
    req_valid = 1'b1; tick(); tick(); req_valid = 1'b0;
    check("full no send", o_flit_valid, 0);
    check("full still blocked", req_ready, 0);
    send_resp(16'h1000, 1'b1);
    check("req_ready after one resp", req_ready, 1);
    check("outstanding 3", o_outstanding, 3);

    // Tail sent in the same cycle a response is accepted
    send_resp(16'h2000, 1'b0);
    send_req(16'h0131, 64'h0233_0232_0231_0230, 16'h0333, 1'b1);
    check("same-cycle outstanding", o_outstanding, 3);
    check("same-cycle resp_valid", resp_valid, 0);

    send_resp(16'h3000, 1'b1);
    send_resp(16'h3100, 1'b1);
    send_resp(16'h3200, 1'b1);
    check("drained outstanding", o_outstanding, 0);

    // Unexpected response with nothing outstanding
    i_resp_valid = 1'b1; i_resp_flit = 16'hE0E0; tick();
    check("err pulse", o_err_unexpected, 1);
    i_resp_flit = 16'h00E3; tick();
    check("err one cycle", o_err_unexpected, 0);
    i_resp_flit = 16'h00E2; tick();
    i_resp_flit = 16'h00E1; tick();
    i_resp_flit = 16'h00E0; tick();
    i_resp_flit = 16'hEFEF; tick();
    i_resp_valid = 1'b0;
    check("unexp resp_valid", resp_valid, 1);
    check("unexp head", resp_head, 16'hE0E0);
    check("unexp body", resp_body, 64'h00E3_00E2_00E1_00E0);
    check("unexp tail", resp_tail, 16'hEFEF);
    check("unexp no repeat err", o_err_unexpected, 0);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    check("unexp count floor", o_outstanding, 0);

    // Reset mid TX_BODY and mid RX_COLLECT
    send_req(16'h0141, 64'h0243_0242_0241_0240, 16'h0343, 1'b0);
    check("pre-reset outstanding", o_outstanding, 1);
    req_valid = 1'b1; req_head = 16'h7777; req_body = 64'h8003_8002_8001_8000; req_tail = 16'h9999;
    i_resp_valid = 1'b1; i_resp_flit = 16'hD0D0;
    tick();
    req_valid = 1'b0; i_resp_flit = 16'h00D1;
    tick();
    check("mid body flit", o_flit, 16'h8003);
    #3 resetn = 1'b0;
    #1 check_reset_outputs("async reset");
    i_resp_valid = 1'b0;
    #1 resetn = 1'b1;
    tick();
    send_req(16'h1111, 64'h2333_2222_2111_2000, 16'h3333, 1'b0);
    check("post-reset outstanding", o_outstanding, 1);
    check("post-reset rx idle", resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
